intr_ctrl_core: RTL and testbench

INTR_CTRL_CORE -- requirements
Module: intr_ctrl_core

---
 rtl/intr_ctrl_core.sv | 131 +++++++++++++
 tb/tb_intr_ctrl_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl_core.sv
// intr_ctrl_core: priority interrupt controller core with IRR/ISR, rotating or nested priority, EOI handling.
// Ports: clk, reset (sync, active-high); irq_in request lines; level_or_edge_flag 1=level 0=edge;
//   mask excludes channels from resolution; rotate_en selects automatic rotation; inta ack pulse;
//   eoi / eoi_specific / eoi_id end-of-interrupt; int_out / int_id registered CPU request;
//   irr / isr request and in-service registers.
// Optional: define INTR_AEOI_EN to add aeoi_mode (automatic EOI on acknowledge).
module intr_ctrl_core #(
   parameter int NUM_IRQ = 8,
   parameter int IDW     = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               level_or_edge_flag,
   input  logic [NUM_IRQ-1:0] mask,
   input  logic               rotate_en,
   input  logic               inta,
   input  logic               eoi,
   input  logic               eoi_specific,
   input  logic [IDW-1:0]     eoi_id,
`ifdef INTR_AEOI_EN
   input  logic               aeoi_mode,
`endif
   output logic               int_out,
   output logic [IDW-1:0]     int_id,
   output logic [NUM_IRQ-1:0] irr,
   output logic [NUM_IRQ-1:0] isr
);
   typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;
   state_t st_q, st_d;
   logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, prev_q, pend, ack_clr, eoi_clr, ack_set;
   logic [IDW-1:0]     lp_q, lp_d, lp_eff, cand, hi, eoi_tgt, int_id_q, int_id_d;
   logic               int_out_q, int_out_d, cand_v, hi_v, stop, ack, eoi_v, aeoi;
`ifdef INTR_AEOI_EN
   assign aeoi = aeoi_mode;
`else
   assign aeoi = 1'b0;
`endif
   assign pend   = irr_q & ~mask;
   assign lp_eff = rotate_en ? lp_q : IDW'(NUM_IRQ-1);
   assign ack    = (st_q == REQ) && inta;
   // Walk channels from highest to lowest priority: the first set isr bit blocks
   // everything below it, so a candidate must be found before reaching one.
   always_comb begin
      int idx;
      idx    = 0;
      cand_v = 1'b0;
      cand   = '0;
      hi_v   = 1'b0;
      hi     = '0;
      stop   = 1'b0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         idx = int'(lp_eff) + 1 + k;
         if (idx >= NUM_IRQ) idx -= NUM_IRQ;
         if (!hi_v && isr_q[idx]) begin
            hi_v = 1'b1;
            hi   = IDW'(idx);
         end
         if (!stop) begin
            if (isr_q[idx]) stop = 1'b1;
            else if (pend[idx]) begin
               cand_v = 1'b1;
               cand   = IDW'(idx);
               stop   = 1'b1;
            end
         end
      end
   end
   // EOI acts on the pre-acknowledge isr; the acknowledge bit is OR-ed in afterwards.
   assign eoi_tgt = eoi_specific ? eoi_id : hi;
   assign eoi_v   = eoi && (eoi_specific ? (int'(eoi_id) < NUM_IRQ) && isr_q[eoi_id] : hi_v);
   assign eoi_clr = eoi_v ? NUM_IRQ'(1) << eoi_tgt : '0;
   assign ack_set = (ack && !aeoi) ? NUM_IRQ'(1) << int_id_q : '0;
   assign ack_clr = (ack && !level_or_edge_flag) ? NUM_IRQ'(1) << int_id_q : '0;
   assign isr_d   = (isr_q & ~eoi_clr) | ack_set;
   // A new edge in the acknowledge cycle re-arms the request.
   assign irr_d   = level_or_edge_flag ? irq_in : (irr_q & ~ack_clr) | (irq_in & ~prev_q);
   assign lp_d    = (ack && aeoi && rotate_en) ? int_id_q : (eoi_v && rotate_en) ? eoi_tgt : lp_q;
   always_comb begin
      st_d      = st_q;
      int_out_d = int_out_q;
      int_id_d  = int_id_q;
      case (st_q)
         IDLE: if (cand_v) begin
            st_d      = REQ;
            int_out_d = 1'b1;
            int_id_d  = cand;
         end
         REQ: if (inta) begin
            st_d      = ACKD;
            int_out_d = 1'b0;
         end else if (!cand_v) begin
            st_d      = IDLE;
            int_out_d = 1'b0;
         end else int_id_d = cand;
         ACKD: begin
            st_d      = IDLE;
            int_out_d = 1'b0;
         end
         default: begin
            st_d      = IDLE;
            int_out_d = 1'b0;
         end
      endcase
   end
   // Reset loads the edge history with the live lines so a request held high
   // through reset is not mistaken for a fresh rising edge afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q      <= IDLE;
         irr_q     <= '0;
         isr_q     <= '0;
         prev_q    <= irq_in;
         lp_q      <= IDW'(NUM_IRQ-1);
         int_out_q <= 1'b0;
         int_id_q  <= '0;
      end else begin
         st_q      <= st_d;
         irr_q     <= irr_d;
         isr_q     <= isr_d;
         prev_q    <= irq_in;
         lp_q      <= lp_d;
         int_out_q <= int_out_d;
         int_id_q  <= int_id_d;
      end
   end
   assign int_out = int_out_q;
   assign int_id  = int_id_q;
   assign irr     = irr_q;
   assign isr     = isr_q;
endmodule

// File: tb/tb_intr_ctrl_core.sv
// tb_intr_ctrl_core: directed table-driven bench for intr_ctrl_core (NUM_IRQ=8).
module tb_intr_ctrl_core;
   logic       clk = 1'b0;
   logic       reset, level_or_edge_flag, rotate_en, inta, eoi, eoi_specific;
   logic [7:0] irq_in, mask;
   logic [2:0] eoi_id;
`ifdef INTR_AEOI_EN
   logic       aeoi_mode;
`endif
   logic       int_out;
   logic [2:0] int_id;
   logic [7:0] irr, isr;
   intr_ctrl_core #(.NUM_IRQ(8), .IDW(3)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .level_or_edge_flag(level_or_edge_flag),
      .mask(mask), .rotate_en(rotate_en), .inta(inta), .eoi(eoi), .eoi_specific(eoi_specific),
      .eoi_id(eoi_id),
`ifdef INTR_AEOI_EN
      .aeoi_mode(aeoi_mode),
`endif
      .int_out(int_out), .int_id(int_id), .irr(irr), .isr(isr)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic rst, lvl, rot;
      logic [7:0] irq, msk;
      logic ack, eo, sp;
      logic [2:0] eid;
      logic o;
      logic [2:0] id;
      logic [7:0] irr, isr;
   } vec_t;
   vec_t tv[$];
   int checks = 0, errors = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic add(input logic rst, lvl, rot, input logic [7:0] q, m, input logic a, e, s,
                      input logic [2:0] ei, input logic o, input logic [2:0] id,
                      input logic [7:0] ir, is);
      vec_t v;
      v.rst = rst; v.lvl = lvl; v.rot = rot; v.irq = q; v.msk = m; v.ack = a; v.eo = e;
      v.sp = s; v.eid = ei; v.o = o; v.id = id; v.irr = ir; v.isr = is;
      tv.push_back(v);
   endtask
   initial begin
      int lat;
      reset = 1; level_or_edge_flag = 0; rotate_en = 0; inta = 0; eoi = 0; eoi_specific = 0;
      irq_in = 0; mask = 0; eoi_id = 0;
`ifdef INTR_AEOI_EN
      aeoi_mode = 0;
`endif
      cyc; cyc;
      chk("rst int_out", int_out, 0); chk("rst int_id", int_id, 0);
      chk("rst irr", irr, 0); chk("rst isr", isr, 0);
      //   rst lvl rot irq    msk    ack eoi sp eid  out id irr    isr
      add(0, 0, 0, 8'h08, 8'h00, 0, 0, 0, 0,   0, 0, 8'h08, 8'h00);
      add(0, 0, 0, 8'h08, 8'h00, 0, 0, 0, 0,   1, 3, 8'h08, 8'h00);
      add(0, 0, 0, 8'h08, 8'h00, 1, 0, 0, 0,   0, 3, 8'h00, 8'h08);
      add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0,   0, 3, 8'h00, 8'h08);
      add(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0,   0, 3, 8'h00, 8'h00);
      add(0, 0, 0, 8'h20, 8'h00, 0, 0, 0, 0,   0, 3, 8'h20, 8'h00);
      add(0, 0, 0, 8'h20, 8'h00, 0, 0, 0, 0,   1, 5, 8'h20, 8'h00);
      add(0, 0, 0, 8'h20, 8'h00, 1, 0, 0, 0,   0, 5, 8'h00, 8'h20);
      add(0, 0, 0, 8'h60, 8'h00, 0, 0, 0, 0,   0, 5, 8'h40, 8'h20);
      add(0, 0, 0, 8'h60, 8'h00, 0, 0, 0, 0,   0, 5, 8'h40, 8'h20);
      add(0, 0, 0, 8'h64, 8'h00, 0, 0, 0, 0,   0, 5, 8'h44, 8'h20);
      add(0, 0, 0, 8'h64, 8'h00, 0, 0, 0, 0,   1, 2, 8'h44, 8'h20);
      add(0, 0, 0, 8'h64, 8'h00, 1, 0, 0, 0,   0, 2, 8'h40, 8'h24);
      add(0, 0, 0, 8'h64, 8'h00, 0, 0, 0, 0,   0, 2, 8'h40, 8'h24);
      add(0, 0, 0, 8'h64, 8'h00, 0, 1, 0, 0,   0, 2, 8'h40, 8'h20);
      add(0, 0, 0, 8'h64, 8'h00, 0, 0, 0, 0,   0, 2, 8'h40, 8'h20);
      add(0, 0, 0, 8'h64, 8'h00, 0, 1, 1, 5,   0, 2, 8'h40, 8'h00);
      add(0, 0, 0, 8'h64, 8'h00, 0, 0, 0, 0,   1, 6, 8'h40, 8'h00);
      add(0, 0, 0, 8'h64, 8'h00, 1, 0, 0, 0,   0, 6, 8'h00, 8'h40);
      add(0, 0, 0, 8'h64, 8'h00, 0, 1, 1, 3,   0, 6, 8'h00, 8'h40);
      add(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0,   0, 6, 8'h00, 8'h00);
      add(0, 0, 1, 8'h01, 8'h00, 0, 0, 0, 0,   0, 6, 8'h01, 8'h00);
      add(0, 0, 1, 8'h01, 8'h00, 0, 0, 0, 0,   1, 0, 8'h01, 8'h00);
      add(0, 0, 1, 8'h01, 8'h00, 1, 0, 0, 0,   0, 0, 8'h00, 8'h01);
      add(0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0,   0, 0, 8'h00, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   0, 0, 8'h03, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   1, 1, 8'h03, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 1, 0, 0, 0,   0, 1, 8'h01, 8'h02);
      add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0,   0, 1, 8'h01, 8'h02);
      add(0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0,   0, 1, 8'h01, 8'h00);
      add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0,   1, 0, 8'h01, 8'h00);
      add(0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0,   0, 0, 8'h00, 8'h01);
      add(0, 0, 1, 8'h00, 8'h00, 0, 1, 1, 0,   0, 0, 8'h00, 8'h00);
      add(0, 0, 0, 8'h10, 8'h00, 0, 0, 0, 0,   0, 0, 8'h10, 8'h00);
      add(0, 0, 0, 8'h10, 8'h00, 0, 0, 0, 0,   1, 4, 8'h10, 8'h00);
      add(0, 0, 0, 8'h10, 8'h10, 0, 0, 0, 0,   0, 4, 8'h10, 8'h00);
      add(0, 0, 0, 8'h10, 8'h10, 0, 0, 0, 0,   0, 4, 8'h10, 8'h00);
      add(0, 0, 0, 8'h10, 8'h00, 0, 0, 0, 0,   1, 4, 8'h10, 8'h00);
      add(0, 0, 0, 8'h10, 8'h00, 1, 0, 0, 0,   0, 4, 8'h00, 8'h10);
      add(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0,   0, 4, 8'h00, 8'h00);
      add(0, 0, 0, 8'h02, 8'h00, 0, 0, 0, 0,   0, 4, 8'h02, 8'h00);
      add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0,   1, 1, 8'h02, 8'h00);
      add(0, 0, 0, 8'h02, 8'h00, 1, 0, 0, 0,   0, 1, 8'h02, 8'h02);
      add(0, 0, 0, 8'h02, 8'h00, 0, 0, 0, 0,   0, 1, 8'h02, 8'h02);
      add(0, 0, 0, 8'h02, 8'h00, 0, 1, 0, 0,   0, 1, 8'h02, 8'h00);
      add(0, 0, 0, 8'h02, 8'h00, 0, 0, 0, 0,   1, 1, 8'h02, 8'h00);
      add(0, 0, 0, 8'h02, 8'h00, 1, 0, 0, 0,   0, 1, 8'h00, 8'h02);
      add(0, 0, 0, 8'h02, 8'h00, 0, 1, 0, 0,   0, 1, 8'h00, 8'h00);
      add(0, 0, 0, 8'h20, 8'h00, 0, 0, 0, 0,   0, 1, 8'h20, 8'h00);
      add(0, 0, 0, 8'h20, 8'h00, 0, 0, 0, 0,   1, 5, 8'h20, 8'h00);
      add(0, 0, 0, 8'h20, 8'h00, 1, 0, 0, 0,   0, 5, 8'h00, 8'h20);
      add(0, 0, 0, 8'h24, 8'h00, 0, 0, 0, 0,   0, 5, 8'h04, 8'h20);
      add(0, 0, 0, 8'h24, 8'h00, 0, 0, 0, 0,   1, 2, 8'h04, 8'h20);
      add(0, 0, 0, 8'h24, 8'h00, 1, 1, 0, 0,   0, 2, 8'h00, 8'h04);
      add(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0,   0, 2, 8'h00, 8'h00);
      add(0, 1, 0, 8'h08, 8'h00, 0, 0, 0, 0,   0, 2, 8'h08, 8'h00);
      add(0, 1, 0, 8'h08, 8'h00, 0, 0, 0, 0,   1, 3, 8'h08, 8'h00);
      add(0, 1, 0, 8'h08, 8'h00, 1, 0, 0, 0,   0, 3, 8'h08, 8'h08);
      add(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0,   0, 3, 8'h00, 8'h08);
      add(0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0,   0, 3, 8'h00, 8'h00);
      add(0, 1, 0, 8'h40, 8'h00, 0, 0, 0, 0,   0, 3, 8'h40, 8'h00);
      add(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0,   1, 6, 8'h00, 8'h00);
      add(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0,   0, 6, 8'h00, 8'h00);
      add(0, 0, 0, 8'h80, 8'h00, 0, 0, 0, 0,   0, 6, 8'h80, 8'h00);
      add(0, 0, 0, 8'h81, 8'h00, 0, 0, 0, 0,   1, 7, 8'h81, 8'h00);
      add(0, 0, 0, 8'h81, 8'h00, 0, 0, 0, 0,   1, 0, 8'h81, 8'h00);
      add(0, 0, 0, 8'h81, 8'h00, 1, 0, 0, 0,   0, 0, 8'h80, 8'h01);
      add(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0,   0, 0, 8'h80, 8'h00);
      add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0,   1, 7, 8'h80, 8'h00);
      add(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0,   0, 7, 8'h00, 8'h80);
      add(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0,   0, 7, 8'h00, 8'h00);
      add(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0,   0, 7, 8'h00, 8'h00);
      add(0, 0, 1, 8'h01, 8'h00, 0, 0, 0, 0,   0, 7, 8'h01, 8'h00);
      add(0, 0, 1, 8'h01, 8'h00, 0, 0, 0, 0,   1, 0, 8'h01, 8'h00);
      add(0, 0, 1, 8'h01, 8'h00, 1, 0, 0, 0,   0, 0, 8'h00, 8'h01);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   0, 0, 8'h02, 8'h01);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   1, 1, 8'h02, 8'h01);
      add(1, 0, 1, 8'h03, 8'h00, 1, 1, 0, 0,   0, 0, 8'h00, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00);
      add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   0, 0, 8'h03, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   1, 0, 8'h03, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 1, 0, 0, 0,   0, 0, 8'h02, 8'h01);
      add(0, 0, 1, 8'h03, 8'h00, 0, 1, 0, 0,   0, 0, 8'h02, 8'h00);
      add(0, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0,   1, 1, 8'h02, 8'h00);
      add(1, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00);
      foreach (tv[i]) begin
         reset = tv[i].rst; level_or_edge_flag = tv[i].lvl; rotate_en = tv[i].rot;
         irq_in = tv[i].irq; mask = tv[i].msk; inta = tv[i].ack; eoi = tv[i].eo;
         eoi_specific = tv[i].sp; eoi_id = tv[i].eid;
         cyc;
         chk($sformatf("v%0d int_out", i), int_out, tv[i].o);
         chk($sformatf("v%0d int_id", i), int_id, tv[i].id);
         chk($sformatf("v%0d irr", i), irr, tv[i].irr);
         chk($sformatf("v%0d isr", i), isr, tv[i].isr);
      end
      reset = 0; rotate_en = 0; inta = 0; eoi = 0; eoi_specific = 0; irq_in = 0;
      cyc;
      irq_in = 8'h20;
      lat = 0;
      do begin
         cyc;
         lat++;
      end while (!int_out && lat < 8);
      chk("edge latency", lat, 2);
      chk("latency int_id", int_id, 5);
      inta = 1; cyc; inta = 0;
      chk("latency ack isr", isr, 8'h20);
      eoi = 1; cyc; eoi = 0;
      chk("latency eoi isr", isr, 8'h00);
`ifdef INTR_AEOI_EN
      aeoi_mode = 1; irq_in = 8'h04;
      cyc; cyc;
      chk("aeoi int_out", int_out, 1); chk("aeoi int_id", int_id, 2);
      inta = 1; cyc; inta = 0;
      chk("aeoi isr", isr, 8'h00); chk("aeoi irr", irr, 8'h00);
      irq_in = 8'h06;
      cyc; cyc;
      chk("aeoi next int_out", int_out, 1); chk("aeoi next int_id", int_id, 1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
